fetch_sequencer: RTL and testbench

// - Sequential counterpart to the combinational control decoder.
// - Owns the architectural fetch state the decoder consumes: program counter, decode mode
//   (CurrState), previous instruction word and the compare flags.
// - Drives the instruction to the decoder and applies the decoder's BranchEn/BranchTarget/

---
 rtl/fetch_sequencer_pkg.sv | 16 +
 rtl/fetch_sequencer_prog_counter.sv | 40 ++++
 rtl/fetch_sequencer.sv | 112 +++++++++++
 tb/tb_fetch_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Definitions shared by the fetch sequencer and the control decoder.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'b00,
        SEQ_RUN  = 2'b01,
        SEQ_DONE = 2'b10
    } seq_state_t;

    // Decode modes; the decoder's NextState selects among these.
    localparam logic [1:0] MODE_REG = 2'b00;
    localparam logic [1:0] MODE_TGT = 2'b01;
    localparam logic [1:0] MODE_IMM = 2'b10;
    localparam logic [1:0] MODE_NOP = 2'b11;

endpackage

// File: rtl/fetch_sequencer_prog_counter.sv
// Program counter: clear has priority over load, load over increment.
// Incrementing from all-ones wraps to zero and sets the sticky overrun flag.
module prog_counter #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clear,
    input  logic            i_load,
    input  logic            i_inc,
    input  logic [PC_W-1:0] i_load_val,
    output logic [PC_W-1:0] o_pc,
    output logic            o_overrun
);

    logic [PC_W-1:0] r_pc;
    logic            r_overrun;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc      <= START_PC;
            r_overrun <= 1'b0;
        end else if (i_clear) begin
            r_pc      <= START_PC;
            r_overrun <= 1'b0;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_W'(1);
            if (&r_pc) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_pc      = r_pc;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/fetch_sequencer.sv
// Sequential fetch state feeding the control decoder: PC, decode mode, previous
// word, compare flags, and the Start/Done program handshake.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter int              CYC_W    = 16,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [8:0]       InstrIn,
    output logic [PC_W-1:0]  ProgCtr,
    output logic [8:0]       Instruction,
    output logic [8:0]       PrevInstruction,
    output logic [1:0]       CurrState,
    output logic [2:0]       CMPBits,
    input  logic             BranchEn,
    input  logic [8:0]       BranchTarget,
    input  logic [1:0]       NextState,
    input  logic [8:0]       PrevInstructionOut,
    input  logic             CMPLoadEn,
    input  logic [2:0]       CMPBitsIn,
    input  logic             DecAck,
    output logic             Done,
    output logic [CYC_W-1:0] CycleCount,
    output logic             Overrun
);

    seq_state_t       r_state;
    logic [1:0]       r_curr_state;
    logic [8:0]       r_prev_instr;
    logic [2:0]       r_cmp_bits;
    logic             r_done;
    logic [CYC_W-1:0] r_cycle_count;

    logic             w_run;
    logic             w_advance;
    logic [PC_W-1:0]  w_branch_pc;

    assign w_run       = (r_state == SEQ_RUN);
    // DecAck and Start both override normal advancement, including a pending branch.
    assign w_advance   = w_run && !Start && !DecAck;
    assign w_branch_pc = PC_W'(BranchTarget);

    prog_counter #(
        .PC_W     (PC_W),
        .START_PC (START_PC)
    ) u_prog_counter (
        .i_clk      (Clk),
        .i_rst      (Reset),
        .i_clear    (Start),
        .i_load     (w_advance && BranchEn),
        .i_inc      (w_advance && !BranchEn),
        .i_load_val (w_branch_pc),
        .o_pc       (ProgCtr),
        .o_overrun  (Overrun)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= SEQ_IDLE;
        end else begin
            case (r_state)
                SEQ_IDLE: if (!Start) r_state <= SEQ_RUN;
                SEQ_RUN: begin
                    if (Start)       r_state <= SEQ_IDLE;
                    else if (DecAck) r_state <= SEQ_DONE;
                end
                SEQ_DONE: if (Start) r_state <= SEQ_IDLE;
                default:  r_state <= SEQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_curr_state  <= MODE_REG;
            r_prev_instr  <= 9'b0;
            r_cmp_bits    <= 3'b0;
            r_done        <= 1'b0;
            r_cycle_count <= '0;
        end else if (Start) begin
            r_curr_state  <= MODE_REG;
            r_prev_instr  <= 9'b0;
            r_cmp_bits    <= 3'b0;
            r_done        <= 1'b0;
            r_cycle_count <= '0;
        end else if (w_run && DecAck) begin
            r_done <= 1'b1;
        end else if (w_advance) begin
            r_curr_state <= NextState;
            r_prev_instr <= PrevInstructionOut;
            if (CMPLoadEn) begin
                r_cmp_bits <= CMPBitsIn;
            end
            if (~&r_cycle_count) begin
                r_cycle_count <= r_cycle_count + CYC_W'(1);
            end
        end
    end

    // Outside RUN the decoder sees a NOP so it cannot cause side effects.
    assign Instruction     = w_run ? InstrIn : 9'b0;
    assign CurrState       = r_curr_state;
    assign PrevInstruction = r_prev_instr;
    assign CMPBits         = r_cmp_bits;
    assign Done            = r_done;
    assign CycleCount      = r_cycle_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a default-width instance plus a 4-bit PC /
// 4-bit cycle counter instance for wrap and saturation.
module tb_fetch_sequencer;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic [8:0] InstrIn;
    logic       BranchEn;
    logic [8:0] BranchTarget;
    logic [1:0] NextState;
    logic [8:0] PrevInstructionOut;
    logic       CMPLoadEn;
    logic [2:0] CMPBitsIn;
    logic       DecAck;

    logic [8:0]  ProgCtr;
    logic [8:0]  Instruction;
    logic [8:0]  PrevInstruction;
    logic [1:0]  CurrState;
    logic [2:0]  CMPBits;
    logic        Done;
    logic [15:0] CycleCount;
    logic        Overrun;

    logic       Start4;
    logic       BranchEn4;
    logic       DecAck4;
    logic [3:0] ProgCtr4;
    logic [8:0] Instruction4;
    logic [8:0] PrevInstruction4;
    logic [1:0] CurrState4;
    logic [2:0] CMPBits4;
    logic       Done4;
    logic [3:0] CycleCount4;
    logic       Overrun4;

    int vectors;
    int miscompares;

    fetch_sequencer dut (
        .Clk                (Clk),
        .Reset              (Reset),
        .Start              (Start),
        .InstrIn            (InstrIn),
        .ProgCtr            (ProgCtr),
        .Instruction        (Instruction),
        .PrevInstruction    (PrevInstruction),
        .CurrState          (CurrState),
        .CMPBits            (CMPBits),
        .BranchEn           (BranchEn),
        .BranchTarget       (BranchTarget),
        .NextState          (NextState),
        .PrevInstructionOut (PrevInstructionOut),
        .CMPLoadEn          (CMPLoadEn),
        .CMPBitsIn          (CMPBitsIn),
        .DecAck             (DecAck),
        .Done               (Done),
        .CycleCount         (CycleCount),
        .Overrun            (Overrun)
    );

    fetch_sequencer #(.PC_W(4), .CYC_W(4)) dut4 (
        .Clk                (Clk),
        .Reset              (Reset),
        .Start              (Start4),
        .InstrIn            (InstrIn),
        .ProgCtr            (ProgCtr4),
        .Instruction        (Instruction4),
        .PrevInstruction    (PrevInstruction4),
        .CurrState          (CurrState4),
        .CMPBits            (CMPBits4),
        .BranchEn           (BranchEn4),
        .BranchTarget       (BranchTarget),
        .NextState          (NextState),
        .PrevInstructionOut (PrevInstructionOut),
        .CMPLoadEn          (CMPLoadEn),
        .CMPBitsIn          (CMPBitsIn),
        .DecAck             (DecAck4),
        .Done               (Done4),
        .CycleCount         (CycleCount4),
        .Overrun            (Overrun4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic restart();
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b1;
        #3;
        vectors++;
        if ({ProgCtr, CurrState, PrevInstruction, CMPBits} !== {9'h000, 2'b00, 9'h000, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_regs got pc=%h cs=%b prev=%h cmp=%b want all zero",
                     ProgCtr, CurrState, PrevInstruction, CMPBits);
        end
        vectors++;
        if ({Done, Overrun, CycleCount, Instruction} !== {1'b0, 1'b0, 16'h0000, 9'h000}) begin
            miscompares++;
            $display("FAIL reset_status got done=%b ovr=%b cyc=%0d instr=%h want 0/0/0/000",
                     Done, Overrun, CycleCount, Instruction);
        end
        step();
        Reset = 1'b0;
        InstrIn = 9'h0AB;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({ProgCtr, CycleCount, Instruction} !== {9'h000, 16'h0000, 9'h000}) begin
                miscompares++;
                $display("FAIL idle_hold%0d got pc=%h cyc=%0d instr=%h want 000/0/000",
                         i, ProgCtr, CycleCount, Instruction);
            end
        end
    endtask

    task automatic test_run_and_branch();
        Start = 1'b0;
        InstrIn = 9'h000;
        for (int k = 0; k <= 5; k++) begin
            step();
            InstrIn = 9'h100 + 9'(k);
            #1;
            vectors++;
            if ({ProgCtr, CycleCount, Instruction} !== {9'(k), 16'(k), 9'h100 + 9'(k)}) begin
                miscompares++;
                $display("FAIL run_seq%0d got pc=%h cyc=%0d instr=%h want %h/%0d/%h",
                         k, ProgCtr, CycleCount, Instruction, 9'(k), k, 9'h100 + 9'(k));
            end
        end
        BranchEn = 1'b1;
        BranchTarget = 9'h040;
        NextState = 2'b01;
        step();
        vectors++;
        if ({ProgCtr, CurrState} !== {9'h040, 2'b01}) begin
            miscompares++;
            $display("FAIL branch_take got pc=%h cs=%b want 040/01", ProgCtr, CurrState);
        end
        BranchEn = 1'b0;
        NextState = 2'b00;
        step();
        vectors++;
        if ({ProgCtr, CurrState, CycleCount} !== {9'h041, 2'b00, 16'd7}) begin
            miscompares++;
            $display("FAIL branch_next got pc=%h cs=%b cyc=%0d want 041/00/7",
                     ProgCtr, CurrState, CycleCount);
        end
    endtask

    task automatic test_mode_and_abort();
        Start = 1'b1;
        step();
        vectors++;
        if ({ProgCtr, CycleCount, Done, CurrState} !== {9'h000, 16'h0000, 1'b0, 2'b00}) begin
            miscompares++;
            $display("FAIL abort_clear got pc=%h cyc=%0d done=%b cs=%b want 000/0/0/00",
                     ProgCtr, CycleCount, Done, CurrState);
        end
        Start = 1'b0;
        step();
        for (int k = 0; k < 7; k++) step();
        vectors++;
        if (ProgCtr !== 9'h007) begin
            miscompares++;
            $display("FAIL mode_reach7 got pc=%h want 007", ProgCtr);
        end
        NextState = 2'b10;
        PrevInstructionOut = 9'h12A;
        step();
        vectors++;
        if ({CurrState, PrevInstruction, ProgCtr} !== {2'b10, 9'h12A, 9'h008}) begin
            miscompares++;
            $display("FAIL mode_imm got cs=%b prev=%h pc=%h want 10/12a/008",
                     CurrState, PrevInstruction, ProgCtr);
        end
        NextState = 2'b00;
        PrevInstructionOut = 9'h000;
    endtask

    task automatic test_cmp();
        CMPLoadEn = 1'b1;
        CMPBitsIn = 3'b011;
        step();
        vectors++;
        if (CMPBits !== 3'b011) begin
            miscompares++;
            $display("FAIL cmp_load got %b want 011", CMPBits);
        end
        CMPLoadEn = 1'b0;
        CMPBitsIn = 3'b100;
        step();
        step();
        vectors++;
        if (CMPBits !== 3'b011) begin
            miscompares++;
            $display("FAIL cmp_hold got %b want 011", CMPBits);
        end
    endtask

    task automatic test_done();
        restart();
        BranchEn = 1'b1;
        BranchTarget = 9'h020;
        step();
        vectors++;
        if (ProgCtr !== 9'h020) begin
            miscompares++;
            $display("FAIL done_setup got pc=%h want 020", ProgCtr);
        end
        DecAck = 1'b1;
        BranchTarget = 9'h055;
        CMPLoadEn = 1'b1;
        CMPBitsIn = 3'b111;
        NextState = 2'b11;
        step();
        DecAck = 1'b0;
        BranchEn = 1'b0;
        CMPLoadEn = 1'b0;
        InstrIn = 9'h1FF;
        #1;
        vectors++;
        if ({Done, ProgCtr, Instruction} !== {1'b1, 9'h020, 9'h000}) begin
            miscompares++;
            $display("FAIL done_enter got done=%b pc=%h instr=%h want 1/020/000",
                     Done, ProgCtr, Instruction);
        end
        vectors++;
        if ({CurrState, CMPBits, CycleCount} !== {2'b00, 3'b000, 16'd1}) begin
            miscompares++;
            $display("FAIL done_freeze got cs=%b cmp=%b cyc=%0d want 00/000/1",
                     CurrState, CMPBits, CycleCount);
        end
        step();
        vectors++;
        if ({Done, ProgCtr} !== {1'b1, 9'h020}) begin
            miscompares++;
            $display("FAIL done_hold got done=%b pc=%h want 1/020", Done, ProgCtr);
        end
        NextState = 2'b00;
        Start = 1'b1;
        step();
        vectors++;
        if ({Done, ProgCtr, CycleCount, Instruction} !== {1'b0, 9'h000, 16'h0000, 9'h000}) begin
            miscompares++;
            $display("FAIL done_exit got done=%b pc=%h cyc=%0d instr=%h want 0/000/0/000",
                     Done, ProgCtr, CycleCount, Instruction);
        end
    endtask

    task automatic test_wrap();
        Start4 = 1'b1;
        step();
        Start4 = 1'b0;
        step();
        for (int k = 0; k < 15; k++) step();
        vectors++;
        if ({ProgCtr4, Overrun4, CycleCount4} !== {4'hF, 1'b0, 4'hF}) begin
            miscompares++;
            $display("FAIL wrap_pre got pc=%h ovr=%b cyc=%0d want f/0/15",
                     ProgCtr4, Overrun4, CycleCount4);
        end
        step();
        vectors++;
        if ({ProgCtr4, Overrun4, CycleCount4} !== {4'h0, 1'b1, 4'hF}) begin
            miscompares++;
            $display("FAIL wrap_edge got pc=%h ovr=%b cyc=%0d want 0/1/15",
                     ProgCtr4, Overrun4, CycleCount4);
        end
        step();
        vectors++;
        if ({ProgCtr4, Overrun4} !== {4'h1, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_sticky got pc=%h ovr=%b want 1/1", ProgCtr4, Overrun4);
        end
        Start4 = 1'b1;
        step();
        vectors++;
        if ({ProgCtr4, Overrun4} !== {4'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL wrap_clear got pc=%h ovr=%b want 0/0", ProgCtr4, Overrun4);
        end
    endtask

    task automatic test_async_reset();
        Start = 1'b0;
        step();
        NextState = 2'b10;
        PrevInstructionOut = 9'h0F0;
        CMPLoadEn = 1'b1;
        CMPBitsIn = 3'b101;
        step();
        step();
        vectors++;
        if ({ProgCtr, CurrState, CMPBits} !== {9'h002, 2'b10, 3'b101}) begin
            miscompares++;
            $display("FAIL areset_setup got pc=%h cs=%b cmp=%b want 002/10/101",
                     ProgCtr, CurrState, CMPBits);
        end
        #1;
        Reset = 1'b1;
        #1;
        vectors++;
        if ({ProgCtr, CurrState, PrevInstruction, CMPBits, Done, Overrun, CycleCount, Instruction}
            !== {9'h000, 2'b00, 9'h000, 3'b000, 1'b0, 1'b0, 16'h0000, 9'h000}) begin
            miscompares++;
            $display("FAIL areset_clear got pc=%h cs=%b prev=%h cmp=%b done=%b ovr=%b cyc=%0d instr=%h want zeros",
                     ProgCtr, CurrState, PrevInstruction, CMPBits, Done, Overrun, CycleCount, Instruction);
        end
        step();
        Reset = 1'b0;
        CMPLoadEn = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        Reset = 1'b1;
        Start = 1'b1;
        Start4 = 1'b1;
        InstrIn = 9'h000;
        BranchEn = 1'b0;
        BranchEn4 = 1'b0;
        BranchTarget = 9'h000;
        NextState = 2'b00;
        PrevInstructionOut = 9'h000;
        CMPLoadEn = 1'b0;
        CMPBitsIn = 3'b000;
        DecAck = 1'b0;
        DecAck4 = 1'b0;

        test_reset();
        test_run_and_branch();
        test_mode_and_abort();
        test_cmp();
        test_done();
        test_wrap();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
